// File: rtl/tty_tx_arbiter_if.sv
// ============================================================================
// Module   : tty_tx_arbiter_if
// Purpose  : Bundles the requester-side byte handshakes and the tty_tx-side
//            valid/data/ready link of tty_tx_arbiter.
// Ports    : req_valid/req_data/req_last/req_ready  requester byte streams
//            tx_valid/tx_data/tx_ready              tty_tx link
//            grant/busy                             ownership status
//            slave  modport: the arbiter view
//            master modport: the requester + tty_tx view
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tty_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/tty_tx_arbiter.sv
// ============================================================================
// Module   : tty_tx_arbiter
// Purpose  : Shares one tty_tx transmitter between N byte-stream requesters.
//            Round-robin at message granularity: an owner keeps the channel
//            until it sends a byte flagged last, or until it stalls for
//            TIMEOUT cycles mid-message.
// Ports    : clk   clock
//            rstb  asynchronous reset, active-high
//            bus   tty_tx_arbiter_if.slave (requester handshakes, tty_tx
//                  valid/data/ready, grant, busy)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tty_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rstb,
  tty_tx_arbiter_if.slave     bus
);

  localparam int         W       = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   owner_q, owner_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [7:0]     data_arr [N];
  logic [W-1:0]   pick;
  logic           pick_vld;
  logic [W-1:0]   scan_idx;
  logic [W-1:0]   owner_next;
  logic [N-1:0]   owner_onehot;
  logic           in_send;
  logic           own_valid;
  logic           own_last;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: scan from ptr upward with wrap. Iterating from the
  // far end down lets the nearest requester overwrite earlier hits.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = W'((int'(ptr_q) + k) % N);
      if (bus.req_valid[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_next   = (owner_q == W'(N - 1)) ? '0 : owner_q + W'(1);
  assign owner_onehot = {{(N-1){1'b0}}, 1'b1} << owner_q;
  assign in_send      = (state_q == ST_SEND);
  assign own_valid    = bus.req_valid[owner_q];
  assign own_last     = bus.req_last[owner_q];

  // Next-state logic. tx_ready is checked before the stall timer so an
  // acknowledged byte always wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_vld) begin
          owner_d = pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          if (own_last) begin
            state_d = ST_IDLE;
            ptr_d   = owner_next;
            cnt_d   = '0;
          end else if (own_valid) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (own_valid) begin
          cnt_d = '0;
        end else if (cnt_q >= TO_LAST) begin
          // Owner stalled mid-message: drop it without acknowledging.
          state_d = ST_IDLE;
          ptr_d   = owner_next;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state register so an asynchronous
  // reset clears them without waiting for a clock edge.
  assign bus.grant     = in_send ? owner_onehot : '0;
  assign bus.busy      = in_send;
  assign bus.tx_valid  = in_send & own_valid;
  assign bus.tx_data   = in_send ? data_arr[owner_q] : 8'h00;
  assign bus.req_ready = (in_send & bus.tx_ready) ? owner_onehot : '0;

endmodule

`default_nettype wire
